// File: rtl/decoder_pkg.sv
// Shared types and match patterns for the registered instruction decode stage.
package decoder_pkg;

   localparam int unsigned INSTR_W   = 9;
   localparam int unsigned IMM_CHUNK = 4;

   // Result classes; PFX is internal only and never presented on the output.
   typedef enum logic [2:0] {
      CLS_R3  = 3'd0,
      CLS_BR  = 3'd1,
      CLS_JMP = 3'd2,
      CLS_R2  = 3'd3,
      CLS_R1  = 3'd4,
      CLS_IMM = 3'd5,
      CLS_ILL = 3'd6,
      CLS_PFX = 3'd7
   } instr_class_t;

   // Listed in match priority order; earlier patterns shadow later ones.
   localparam logic [INSTR_W-1:0] PAT_R3  = 9'b00???????;
   localparam logic [INSTR_W-1:0] PAT_BR  = 9'b0111?????;
   localparam logic [INSTR_W-1:0] PAT_JMP = 9'b10000????;
   localparam logic [INSTR_W-1:0] PAT_R2  = 9'b01???????;
   localparam logic [INSTR_W-1:0] PAT_R1  = 9'b100??????;
   localparam logic [INSTR_W-1:0] PAT_IMM = 9'b101??????;
   localparam logic [INSTR_W-1:0] PAT_PFX = 9'b110??????;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and register-read-side handshake bundle of the decode stage.
interface decode_stage_if
   import decoder_pkg::*;
#(
   parameter int unsigned REG_W = 4,
   parameter int unsigned IMM_W = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [INSTR_W-1:0]   instr;
   logic                 out_valid;
   logic                 out_ready;
   instr_class_t         out_class;
   logic [REG_W-1:0]     out_reg0;
   logic [REG_W-1:0]     out_reg1;
   logic [IMM_W-1:0]     out_imm;
   logic                 out_use_imm;
   logic                 out_pfx_err;

   modport slave (
      input  in_valid, instr, out_ready,
      output in_ready, out_valid, out_class, out_reg0, out_reg1,
             out_imm, out_use_imm, out_pfx_err
   );

   modport master (
      output in_valid, instr, out_ready,
      input  in_ready, out_valid, out_class, out_reg0, out_reg1,
             out_imm, out_use_imm, out_pfx_err
   );
endinterface

// File: rtl/instr_classify.sv
// Combinational field decoder: class, raw register indices and 4-bit immediate.
module instr_classify
   import decoder_pkg::*;
(
   input  logic [INSTR_W-1:0] instr_i,
   output instr_class_t       class_o,
   output logic [2:0]         reg0_o,
   output logic [2:0]         reg1_o,
   output logic [3:0]         imm4_o,
   output logic               use_imm_o
);

   always_comb begin
      class_o   = CLS_ILL;
      reg0_o    = 3'd0;
      reg1_o    = 3'd0;
      imm4_o    = 4'd0;
      use_imm_o = 1'b0;
      if (instr_i ==? PAT_R3) begin
         class_o = CLS_R3;
         reg0_o  = instr_i[5:3];
         reg1_o  = instr_i[2:0];
      end else if (instr_i ==? PAT_BR) begin
         class_o   = CLS_BR;
         imm4_o    = instr_i[3:0];
         use_imm_o = 1'b1;
      end else if (instr_i ==? PAT_JMP) begin
         class_o   = CLS_JMP;
         imm4_o    = instr_i[3:0];
         use_imm_o = 1'b1;
      end else if (instr_i ==? PAT_R2) begin
         class_o = CLS_R2;
         reg0_o  = {1'b0, instr_i[3:2]};
         reg1_o  = {1'b0, instr_i[1:0]};
      end else if (instr_i ==? PAT_R1) begin
         class_o = CLS_R1;
         reg1_o  = {1'b0, instr_i[3:2]};
      end else if (instr_i ==? PAT_IMM) begin
         class_o   = CLS_IMM;
         imm4_o    = instr_i[3:0];
         use_imm_o = 1'b1;
      end else if (instr_i ==? PAT_PFX) begin
         class_o = CLS_PFX;
         imm4_o  = instr_i[3:0];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with immediate-extension prefixes, backpressure and flush.
// Define DECODE_STAGE_SIGN_EXT_EN to sign-extend BR immediates.
module decode_stage
   import decoder_pkg::*;
#(
   parameter int unsigned REG_W = 4,
   parameter int unsigned IMM_W = 8
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   decode_stage_if.slave bus
);

   localparam int unsigned N_CHUNK = IMM_W / IMM_CHUNK;
   localparam int unsigned PFX_MAX = N_CHUNK - 1;
   localparam int unsigned PEND_W  = (IMM_W > IMM_CHUNK) ? IMM_W - IMM_CHUNK : 1;
   localparam int unsigned CNT_W   = (PFX_MAX > 0) ? $clog2(PFX_MAX + 1) : 1;

   instr_class_t       cls_c;
   logic [2:0]         raw_reg0_c, raw_reg1_c;
   logic [3:0]         imm4_c;
   logic               use_imm_c;

   logic               valid_q, valid_d;
   instr_class_t       class_q, class_d;
   logic [REG_W-1:0]   reg0_q, reg0_d, reg1_q, reg1_d;
   logic [IMM_W-1:0]   imm_q, imm_d;
   logic               use_imm_q, use_imm_d;
   logic               pfx_err_q, pfx_err_d;
   logic [PEND_W-1:0]  pend_q, pend_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;

   logic               in_ready_c, accept_c, fill_c;
   logic [IMM_W-1:0]   imm_full_c, imm_ext_c;

   instr_classify u_classify (
      .instr_i   (bus.instr),
      .class_o   (cls_c),
      .reg0_o    (raw_reg0_c),
      .reg1_o    (raw_reg1_c),
      .imm4_o    (imm4_c),
      .use_imm_o (use_imm_c)
   );

   assign in_ready_c = !flush && (!valid_q || bus.out_ready);
   assign accept_c   = bus.in_valid && in_ready_c;
   assign imm_full_c = IMM_W'({pend_q, imm4_c});

   // Keep only the chunks covered by pending prefixes; above that fill with the extension bit.
   always_comb begin
`ifdef DECODE_STAGE_SIGN_EXT_EN
      logic sign_c;
      sign_c = 1'b0;
      for (int c = 0; c < int'(N_CHUNK); c++) begin
         if (CNT_W'(c) == cnt_q) sign_c = imm_full_c[c*IMM_CHUNK + IMM_CHUNK - 1];
      end
      fill_c = (cls_c == CLS_BR) && sign_c;
`else
      fill_c = 1'b0;
`endif
      imm_ext_c = '0;
      for (int c = 0; c < int'(N_CHUNK); c++) begin
         if (CNT_W'(c) <= cnt_q) imm_ext_c[c*IMM_CHUNK +: IMM_CHUNK] = imm_full_c[c*IMM_CHUNK +: IMM_CHUNK];
         else                    imm_ext_c[c*IMM_CHUNK +: IMM_CHUNK] = {IMM_CHUNK{fill_c}};
      end
   end

   always_comb begin
      valid_d   = valid_q;
      class_d   = class_q;
      reg0_d    = reg0_q;
      reg1_d    = reg1_q;
      imm_d     = imm_q;
      use_imm_d = use_imm_q;
      pfx_err_d = pfx_err_q;
      pend_d    = pend_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      if (flush) begin
         valid_d = 1'b0;
         pend_d  = '0;
         cnt_d   = '0;
         err_d   = 1'b0;
      end else if (accept_c) begin
         if (cls_c == CLS_PFX) begin
            valid_d = 1'b0;
            pend_d  = PEND_W'({pend_q, imm4_c});
            if (cnt_q == CNT_W'(PFX_MAX)) err_d = 1'b1;
            else                          cnt_d = cnt_q + CNT_W'(1);
         end else begin
            valid_d   = 1'b1;
            class_d   = cls_c;
            reg0_d    = REG_W'(raw_reg0_c);
            reg1_d    = REG_W'(raw_reg1_c);
            use_imm_d = use_imm_c;
            imm_d     = use_imm_c ? imm_ext_c : '0;
            pfx_err_d = err_q || (!use_imm_c && (cnt_q != '0));
            pend_d    = '0;
            cnt_d     = '0;
            err_d     = 1'b0;
         end
      end else if (valid_q && bus.out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q   <= 1'b0;
         class_q   <= CLS_R3;
         reg0_q    <= '0;
         reg1_q    <= '0;
         imm_q     <= '0;
         use_imm_q <= 1'b0;
         pfx_err_q <= 1'b0;
         pend_q    <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         class_q   <= class_d;
         reg0_q    <= reg0_d;
         reg1_q    <= reg1_d;
         imm_q     <= imm_d;
         use_imm_q <= use_imm_d;
         pfx_err_q <= pfx_err_d;
         pend_q    <= pend_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = valid_q;
   assign bus.out_class   = class_q;
   assign bus.out_reg0    = reg0_q;
   assign bus.out_reg1    = reg1_q;
   assign bus.out_imm     = imm_q;
   assign bus.out_use_imm = use_imm_q;
   assign bus.out_pfx_err = pfx_err_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions, expected beats queued at issue.
module tb_decode_stage;
   import decoder_pkg::*;

   localparam int unsigned REG_W = 4;
   localparam int unsigned IMM_W = 8;

   typedef struct {
      instr_class_t     cls;
      logic [REG_W-1:0] r0;
      logic [REG_W-1:0] r1;
      logic [IMM_W-1:0] imm;
      logic             use_imm;
      logic             err;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic flush = 1'b0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   decode_stage_if #(.REG_W(REG_W), .IMM_W(IMM_W)) bus ();

   decode_stage #(.REG_W(REG_W), .IMM_W(IMM_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .bus     (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(instr_class_t c, int r0, int r1, int imm, bit u, bit e);
      exp_t x;
      x.cls     = c;
      x.r0      = REG_W'(r0);
      x.r1      = REG_W'(r1);
      x.imm     = IMM_W'(imm);
      x.use_imm = u;
      x.err     = e;
      return x;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [8:0] i);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.instr    = i;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("send_timeout", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic expect_beat(input exp_t e, input logic [8:0] i);
      sb.push_back(e);
      send(i);
   endtask

   // Monitor: every accepted output beat must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: got class %0d imm %0h expected none", bus.out_class, bus.out_imm);
            end else begin
               e = sb.pop_front();
               check("class",   32'(bus.out_class),   32'(e.cls));
               check("reg0",    32'(bus.out_reg0),    32'(e.r0));
               check("reg1",    32'(bus.out_reg1),    32'(e.r1));
               check("imm",     32'(bus.out_imm),     32'(e.imm));
               check("use_imm", 32'(bus.out_use_imm), 32'(e.use_imm));
               check("pfx_err", 32'(bus.out_pfx_err), 32'(e.err));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.instr     = '0;
      bus.out_ready = 1'b0;

      // Reset state
      idle(3);
      @(negedge clk);
      check("rst_valid",   32'(bus.out_valid),   32'd0);
      check("rst_class",   32'(bus.out_class),   32'd0);
      check("rst_reg0",    32'(bus.out_reg0),    32'd0);
      check("rst_reg1",    32'(bus.out_reg1),    32'd0);
      check("rst_imm",     32'(bus.out_imm),     32'd0);
      check("rst_use_imm", 32'(bus.out_use_imm), 32'd0);
      check("rst_pfx_err", 32'(bus.out_pfx_err), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Basic classes, back to back
      bus.out_ready = 1'b1;
      expect_beat(mk(CLS_R3,  5, 3, 8'h00, 0, 0), 9'b000_101_011);
      expect_beat(mk(CLS_BR,  0, 0, 8'h0A, 1, 0), 9'b0111_0_1010);
`ifdef DECODE_STAGE_SIGN_EXT_EN
      expect_beat(mk(CLS_BR,  0, 0, 8'hFE, 1, 0), 9'b0111_0_1110);
`else
      expect_beat(mk(CLS_BR,  0, 0, 8'h0E, 1, 0), 9'b0111_0_1110);
`endif
      expect_beat(mk(CLS_JMP, 0, 0, 8'h07, 1, 0), 9'b10000_0111);
      expect_beat(mk(CLS_R2,  2, 3, 8'h00, 0, 0), 9'b010_00_10_11);
      expect_beat(mk(CLS_R1,  0, 3, 8'h00, 0, 0), 9'b100_10_1100);
      expect_beat(mk(CLS_IMM, 0, 0, 8'h05, 1, 0), 9'b101_00_0101);
      expect_beat(mk(CLS_ILL, 0, 0, 8'h00, 0, 0), 9'b111_000000);

      // Prefix extension, overflow and non-immediate consumer
      send(9'b110_00_0011);
      expect_beat(mk(CLS_IMM, 0, 0, 8'h35, 1, 0), 9'b101_00_0101);
      send(9'b110_00_0011);
      send(9'b110_00_0111);
      expect_beat(mk(CLS_IMM, 0, 0, 8'h75, 1, 1), 9'b101_00_0101);
      send(9'b110_00_0011);
      expect_beat(mk(CLS_R3,  1, 2, 8'h00, 0, 1), 9'b000_001_010);
      expect_beat(mk(CLS_IMM, 0, 0, 8'h05, 1, 0), 9'b101_00_0101);
      send(9'b110_00_0011);
      expect_beat(mk(CLS_JMP, 0, 0, 8'h37, 1, 0), 9'b10000_0111);
      send(9'b110_00_1001);
      expect_beat(mk(CLS_BR,  0, 0, 8'h92, 1, 0), 9'b0111_0_0010);
      idle(3);

      // Backpressure: held beat stays stable, then drains with no bubble
      bus.out_ready = 1'b0;
      expect_beat(mk(CLS_R3, 6, 1, 8'h00, 0, 0), 9'b000_110_001);
      sb.push_back(mk(CLS_IMM, 0, 0, 8'h0C, 1, 0));
      bus.in_valid = 1'b1;
      bus.instr    = 9'b101_00_1100;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(bus.in_ready),  32'd0);
         check("stall_valid",    32'(bus.out_valid), 32'd1);
         check("stall_class",    32'(bus.out_class), 32'(CLS_R3));
         check("stall_reg0",     32'(bus.out_reg0),  32'd6);
         check("stall_reg1",     32'(bus.out_reg1),  32'd1);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("drain_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("no_bubble_valid", 32'(bus.out_valid), 32'd1);
      idle(3);

      // Flush clears pending prefix and overflow error
      send(9'b110_00_0011);
      send(9'b110_00_0111);
      flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      expect_beat(mk(CLS_IMM, 0, 0, 8'h05, 1, 0), 9'b101_00_0101);
      idle(3);

      // Flush drops a held result and refuses a concurrent instr
      bus.out_ready = 1'b0;
      send(9'b000_110_001);
      flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.instr    = 9'b101_00_0101;
      @(negedge clk);
      check("flush_held_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("flush_held_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;

      // Reset mid-stream with a held immediate result
      bus.out_ready = 1'b0;
      send(9'b101_00_0101);
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_rst_valid",   32'(bus.out_valid),   32'd0);
      check("mid_rst_imm",     32'(bus.out_imm),     32'd0);
      check("mid_rst_use_imm", 32'(bus.out_use_imm), 32'd0);
      check("mid_rst_class",   32'(bus.out_class),   32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      bus.out_ready = 1'b1;

      // Reset discards a pending prefix
      send(9'b110_00_0011);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      expect_beat(mk(CLS_IMM, 0, 0, 8'h05, 1, 0), 9'b101_00_0101);
      idle(4);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
